// File: rtl/mul_karatsuba_pipe.sv
// mul_karatsuba_pipe: pipelined one-level Karatsuba multiplier with a
// valid/ready stream interface, per-operation signed mode and tag passthrough.

module mul_karatsuba_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("mul_karatsuba_pipe: WIDTH must be even and >= 4");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("mul_karatsuba_pipe: TAG_W must be >= 1");
        end
    endgenerate

    typedef struct packed {
        logic             valid;
        logic [H-1:0]     a_hi;
        logic [H-1:0]     a_lo;
        logic [H-1:0]     b_hi;
        logic [H-1:0]     b_lo;
        logic [H:0]       sa;
        logic [H:0]       sb;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic [2*H-1:0]   z0;
        logic [2*H-1:0]   z2;
        logic [2*H+1:0]   z1;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic             valid;
        logic [PW-1:0]    p;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } s3_t;

    logic             adv;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [2*H+1:0]   mid;
    s1_t              s1_d;
    s1_t              s1_q;
    s2_t              s2_d;
    s2_t              s2_q;
    s3_t              s3_d;
    s3_t              s3_q;

    // One global enable: everything moves unless a result is waiting
    // at the output and the consumer refuses it.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // S1: magnitudes, result sign, half split and half sums.
    always_comb begin
        mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;

        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.a_hi  = mag_a[WIDTH-1:H];
        s1_d.a_lo  = mag_a[H-1:0];
        s1_d.b_hi  = mag_b[WIDTH-1:H];
        s1_d.b_lo  = mag_b[H-1:0];
        s1_d.sa    = {1'b0, mag_a[WIDTH-1:H]} + {1'b0, mag_a[H-1:0]};
        s1_d.sb    = {1'b0, mag_b[WIDTH-1:H]} + {1'b0, mag_b[H-1:0]};
        s1_d.neg   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        s1_d.tag   = in_tag;
    end

    // S2: the three half-width partial products.
    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.z0    = {{H{1'b0}}, s1_q.a_lo} * {{H{1'b0}}, s1_q.b_lo};
        s2_d.z2    = {{H{1'b0}}, s1_q.a_hi} * {{H{1'b0}}, s1_q.b_hi};
        s2_d.z1    = {{(H+1){1'b0}}, s1_q.sa} * {{(H+1){1'b0}}, s1_q.sb};
        s2_d.neg   = s1_q.neg;
        s2_d.tag   = s1_q.tag;
    end

    // S3: recombine; mid is a_hi*b_lo + a_lo*b_hi and so never negative.
    always_comb begin
        mid = s2_q.z1 - {2'b00, s2_q.z2} - {2'b00, s2_q.z0};

        s3_d       = '0;
        s3_d.valid = s2_q.valid;
        s3_d.p     = (PW'(s2_q.z2) << WIDTH)
                   + (PW'(mid) << H)
                   + PW'(s2_q.z0);
        s3_d.neg   = s2_q.neg;
        s3_d.tag   = s2_q.tag;
    end

    // Stage registers shift together, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else if (adv) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Output register applies the sign; negating zero yields zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_product <= '0;
            out_tag     <= '0;
        end else if (adv) begin
            out_valid   <= s3_q.valid;
            out_product <= s3_q.neg ? -s3_q.p : s3_q.p;
            out_tag     <= s3_q.tag;
        end
    end

endmodule

// File: tb/tb_mul_karatsuba_pipe.sv
// tb_mul_karatsuba_pipe: directed and random checks of mul_karatsuba_pipe
// at WIDTH=16, plus random streams at WIDTH=8 and WIDTH=32.

module tb_mul_karatsuba_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [31:0] out_product;

    logic        i8_in_valid, i8_in_ready, i8_in_signed, i8_out_valid, i8_out_ready;
    logic [7:0]  i8_in_a, i8_in_b;
    logic [3:0]  i8_in_tag, i8_out_tag;
    logic [15:0] i8_out_product;

    logic        i32_in_valid, i32_in_ready, i32_in_signed, i32_out_valid, i32_out_ready;
    logic [31:0] i32_in_a, i32_in_b;
    logic [3:0]  i32_in_tag, i32_out_tag;
    logic [63:0] i32_out_product;

    mul_karatsuba_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag)
    );

    mul_karatsuba_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i8_in_valid), .in_ready(i8_in_ready),
        .in_a(i8_in_a), .in_b(i8_in_b), .in_signed(i8_in_signed), .in_tag(i8_in_tag),
        .out_valid(i8_out_valid), .out_ready(i8_out_ready),
        .out_product(i8_out_product), .out_tag(i8_out_tag)
    );

    mul_karatsuba_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i32_in_valid), .in_ready(i32_in_ready),
        .in_a(i32_in_a), .in_b(i32_in_b), .in_signed(i32_in_signed), .in_tag(i32_in_tag),
        .out_valid(i32_out_valid), .out_ready(i32_out_ready),
        .out_product(i32_out_product), .out_tag(i32_out_tag)
    );

    // Present one operation for exactly one accept edge; returns at the
    // falling edge right after that accept.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [3:0] t);
        @(negedge clk);
        in_a = a; in_b = b; in_signed = s; in_tag = t;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        tests++;
        if (out_product !== 32'h0) begin fails++; $display("FAIL reset_product got=%h exp=0", out_product); end
        tests++;
        if (out_tag !== 4'h0) begin fails++; $display("FAIL reset_tag got=%h exp=0", out_tag); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_corners;
        logic [15:0] av [7];
        logic [15:0] bv [7];
        logic        sv [7];
        logic [31:0] ev [7];
        av = '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF};
        bv = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000};
        sv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ev = '{32'h00000000, 32'hFFFE0001, 32'h0000FFFF, 32'h40000000,
               32'hFFFFFFFF, 32'hC0008000, 32'h00000000};
        for (int i = 0; i < 7; i++) begin
            issue(av[i], bv[i], sv[i], 4'(i + 3));
            @(negedge clk);
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL corner%0d_early got=%b exp=0", i, out_valid); end
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1) begin fails++; $display("FAIL corner%0d_valid got=%b exp=1", i, out_valid); end
            tests++;
            if (out_product !== ev[i]) begin fails++; $display("FAIL corner%0d_product got=%h exp=%h", i, out_product, ev[i]); end
            tests++;
            if (out_tag !== 4'(i + 3)) begin fails++; $display("FAIL corner%0d_tag got=%h exp=%h", i, out_tag, 4'(i + 3)); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int got = 0;
        int c = 0;
        logic [31:0] held = '0;
        logic have_held = 1'b0;
        while ((sent < 8 || got < 8) && c < 60) begin
            @(negedge clk);
            in_valid = (sent < 8);
            in_a = 16'(sent + 2); in_b = 16'd3; in_signed = 1'b0; in_tag = 4'(sent);
            out_ready = !(c >= 4 && c <= 9);
            #1;
            if (out_valid && !out_ready) begin
                tests++;
                if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
                if (have_held) begin
                    tests++;
                    if (out_product !== held) begin fails++; $display("FAIL bp_stable c=%0d got=%h exp=%h", c, out_product, held); end
                end
                held = out_product;
                have_held = 1'b1;
            end else begin
                have_held = 1'b0;
            end
            if (out_valid && out_ready) begin
                tests++;
                if (out_tag !== 4'(got)) begin fails++; $display("FAIL bp_tag got=%h exp=%h", out_tag, 4'(got)); end
                tests++;
                if (out_product !== 32'((got + 2) * 3)) begin fails++; $display("FAIL bp_product got=%h exp=%h", out_product, 32'((got + 2) * 3)); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            c++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        tests++;
        if (sent != 8 || got != 8) begin fails++; $display("FAIL bp_count sent=%0d got=%0d exp=8/8", sent, got); end
    endtask

    task automatic test_bubbles;
        logic vin [16];
        logic expv;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            in_valid = (c < 8) && (c % 2 == 0);
            in_a = 16'(c + 1); in_b = 16'd7; in_signed = 1'b0; in_tag = 4'(c);
            out_ready = 1'b1;
            vin[c] = in_valid;
            #1;
            expv = (c >= 4) ? vin[c-4] : 1'b0;
            tests++;
            if (out_valid !== expv) begin fails++; $display("FAIL bubble_valid c=%0d got=%b exp=%b", c, out_valid, expv); end
            if (expv) begin
                tests++;
                if (out_product !== 32'((c - 3) * 7)) begin fails++; $display("FAIL bubble_product c=%0d got=%h exp=%h", c, out_product, 32'((c - 3) * 7)); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight;
        logic seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 16'(i + 10); in_b = 16'd11;
            in_signed = 1'b0; in_tag = 4'(i + 1); out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_first_valid got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_product !== 32'h0 || out_tag !== 4'h0) begin
            fails++;
            $display("FAIL mid_async_clear got=%b/%h/%h exp=0/0/0", out_valid, out_product, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL mid_dropped got=%b exp=0", seen); end
        issue(16'd3, 16'd5, 1'b0, 4'hA);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_product !== 32'd15 || out_tag !== 4'hA) begin
            fails++;
            $display("FAIL mid_after got=%b/%h/%h exp=1/0000000f/a", out_valid, out_product, out_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_random_w8;
        logic [19:0] q [$];
        logic [19:0] ent;
        logic [15:0] e;
        logic [7:0]  a, b;
        logic        s;
        logic [3:0]  t;
        int acc = 0;
        int c = 0;
        while (acc < 1000 && c < 20000) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom);
            s = 1'($urandom_range(0, 1)); t = 4'($urandom);
            i8_in_valid = ($urandom_range(0, 3) != 0);
            i8_in_a = a; i8_in_b = b; i8_in_signed = s; i8_in_tag = t;
            i8_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (i8_out_valid && i8_out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand8_extra got=%h exp=none", i8_out_product);
                end else begin
                    ent = q.pop_front();
                    if ({i8_out_product, i8_out_tag} !== ent) begin
                        fails++; $display("FAIL rand8 got=%h exp=%h", {i8_out_product, i8_out_tag}, ent);
                    end
                end
            end
            if (i8_in_valid && i8_in_ready) begin
                e = s ? {{8{a[7]}}, a} * {{8{b[7]}}, b} : {8'h0, a} * {8'h0, b};
                q.push_back({e, t});
                acc++;
            end
            c++;
        end
        @(negedge clk);
        i8_in_valid = 1'b0; i8_out_ready = 1'b1;
        c = 0;
        while (q.size() > 0 && c < 50) begin
            #1;
            if (i8_out_valid) begin
                ent = q.pop_front();
                tests++;
                if ({i8_out_product, i8_out_tag} !== ent) begin
                    fails++; $display("FAIL rand8_drain got=%h exp=%h", {i8_out_product, i8_out_tag}, ent);
                end
            end
            @(negedge clk);
            c++;
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL rand8_lost got=%0d exp=0", q.size()); end
    endtask

    task automatic test_random_w32;
        logic [67:0] q [$];
        logic [67:0] ent;
        logic [63:0] e;
        logic [31:0] a, b;
        logic        s;
        logic [3:0]  t;
        int acc = 0;
        int c = 0;
        while (acc < 1000 && c < 20000) begin
            @(negedge clk);
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            s = 1'($urandom_range(0, 1)); t = 4'($urandom);
            i32_in_valid = ($urandom_range(0, 3) != 0);
            i32_in_a = a; i32_in_b = b; i32_in_signed = s; i32_in_tag = t;
            i32_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (i32_out_valid && i32_out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand32_extra got=%h exp=none", i32_out_product);
                end else begin
                    ent = q.pop_front();
                    if ({i32_out_product, i32_out_tag} !== ent) begin
                        fails++; $display("FAIL rand32 got=%h exp=%h", {i32_out_product, i32_out_tag}, ent);
                    end
                end
            end
            if (i32_in_valid && i32_in_ready) begin
                e = s ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'h0, a} * {32'h0, b};
                q.push_back({e, t});
                acc++;
            end
            c++;
        end
        @(negedge clk);
        i32_in_valid = 1'b0; i32_out_ready = 1'b1;
        c = 0;
        while (q.size() > 0 && c < 50) begin
            #1;
            if (i32_out_valid) begin
                ent = q.pop_front();
                tests++;
                if ({i32_out_product, i32_out_tag} !== ent) begin
                    fails++; $display("FAIL rand32_drain got=%h exp=%h", {i32_out_product, i32_out_tag}, ent);
                end
            end
            @(negedge clk);
            c++;
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL rand32_lost got=%0d exp=0", q.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b0;
        i8_in_valid = 1'b0; i8_in_a = '0; i8_in_b = '0; i8_in_signed = 1'b0;
        i8_in_tag = '0; i8_out_ready = 1'b1;
        i32_in_valid = 1'b0; i32_in_a = '0; i32_in_b = '0; i32_in_signed = 1'b0;
        i32_in_tag = '0; i32_out_ready = 1'b1;
        @(negedge clk);
        test_reset;
        test_corners;
        test_backpressure;
        test_bubbles;
        test_reset_midflight;
        test_random_w8;
        test_random_w32;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
